game_seg_display: RTL and testbench
===================================

GAME_SEG_DISPLAY -- requirements
Module: game_seg_display

Interface
REQ-001 SHALL have parameter SEC_DIV, default 1_000_000, meaning clk_d cycles per game-timer second (clk_d nominal 1 MHz).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, meaning clk_d cycles each digit is driven before the scan advances.
REQ-003 SHALL have port clk_d, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port game_status, input, 2 bits: 00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED, from the game fsm.
REQ-006 SHALL have port step_number, input, 6 bits: binary move count from the game fsm, range 0-63.
REQ-007 SHALL have port seg_an, output, 8 bits: digit anodes, active-low, bit n selects digit n.
REQ-008 SHALL have port seg_out, output, 8 bits: {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-009 SHALL run a timer FSM with states IDLE, RUN and HOLD, next state decoded from game_status each cycle: 00/10 -> IDLE, 01 -> RUN, 11 -> HOLD.
REQ-010 SHALL, in IDLE, hold the prescaler and the 4-digit BCD seconds count at 0.
REQ-011 SHALL, in RUN, increment the prescaler 0..SEC_DIV-1 and, on the cycle it wraps to 0, add 1 to the BCD seconds count with decimal carry.
REQ-012 SHALL saturate the seconds count at 9999: no wrap, and the prescaler keeps running.
REQ-013 SHALL, in HOLD, freeze both the prescaler and the seconds count.
REQ-014 SHALL, on HOLD->RUN, resume from the frozen values without clearing.
REQ-015 SHALL, on any transition into IDLE, clear both counters on the next edge.
REQ-016 SHALL keep a blink flag that toggles each SEC_DIV/2 cycles while in HOLD, and is 0 in IDLE and RUN.
REQ-017 SHALL convert step_number to two BCD digits (tens 0-6, ones 0-9), sampling step_number every cycle.
REQ-018 SHALL keep a scan counter 0..SCAN_DIV-1 and a 3-bit digit index, incremented at scan-counter wrap, wrapping 7->0.
REQ-019 SHALL map digit index 7..4 to seconds thousands..units, 1 to step tens and 0 to step ones.
REQ-020 SHALL treat digits 3 and 2 as permanently blank.
REQ-021 SHALL blank digits 1 and 0 while the blink flag is 1.
REQ-022 SHALL drive, for a blank digit, seg_an all ones and seg_out 8'hFF.
REQ-023 SHALL drive, otherwise, seg_an with only bit[index] low.
REQ-024 SHALL encode seg_out with dp always off, as 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
REQ-025 SHALL register seg_an and seg_out, so they reflect the digit index and data values one cycle after those values change.
REQ-026 SHALL never drive more than one seg_an bit low at a time.

Reset
REQ-027 SHALL, while rst=0, asynchronously force the state to IDLE, clear the prescaler, seconds count, blink flag, scan counter and digit index, and drive seg_an=8'hFF and seg_out=8'hFF.
REQ-028 SHALL, after rst rises, start the scan at digit 0 with the first registered output one cycle later.

Verification (SEC_DIV=10, SCAN_DIV=2)
REQ-029 Reset release with game_status=00 and step_number=0 -> seg_an cycles FE, FD, then FF for digits 2-3, then EF..7F; seg_out=C0 on every non-blank digit.
REQ-030 game_status=01 held for 125 cycles -> seconds=0012; digit 5 shows F9 and digit 4 shows A4.
REQ-031 Seconds preloaded to 9998 by forcing, 30 cycles of RUN -> display holds at 9999 with no wrap to 0000.
REQ-032 RUN for 35 cycles, then 11 -> seconds frozen at 0003; step digits blank for 5 cycles and visible for 5 cycles, repeating.
REQ-033 step_number=63 -> digit 1 shows 82 and digit 0 shows B0.
REQ-034 rst pulsed low mid-RUN between clock edges -> seg_an=FF immediately (before the next edge), counters read 0, and the scan restarts at digit 0.

Source files
------------

// File: rtl/game_seg_display.sv
// Game timer and move-count display driver for an 8-digit multiplexed
// 7-segment display. Digits 7..4 show elapsed seconds (BCD, saturating at 9999),
// digits 1..0 show the move count, and digits 3..2 stay dark. The timer follows
// the game FSM: it is cleared while idle, counts while playing, and freezes
// after a win, when the move-count digits also blink.
module game_seg_display #(
  parameter int unsigned SEC_DIV  = 1_000_000,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk_d,
  input  logic       rst,
  input  logic [1:0] game_status,
  input  logic [5:0] step_number,
  output logic [7:0] seg_an,
  output logic [7:0] seg_out
);

  // Counter widths; guarded so degenerate divider values still elaborate.
  localparam int unsigned PreW     = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int unsigned BlinkDiv = (SEC_DIV / 2 > 0) ? SEC_DIV / 2 : 1;
  localparam int unsigned BlinkW   = (BlinkDiv > 1) ? $clog2(BlinkDiv) : 1;
  localparam int unsigned ScanW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PreW-1:0]   PreMax   = PreW'(SEC_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BlinkDiv - 1);
  localparam logic [ScanW-1:0]  ScanMax  = ScanW'(SCAN_DIV - 1);

  localparam logic [15:0] SecSat = 16'h9999;
  localparam logic [7:0]  SegOff = 8'hFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PreW-1:0]   presc_q, presc_d;
  logic [15:0]       sec_q, sec_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;
  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]        digit_q, digit_d;
  logic [7:0]        seg_an_q, seg_an_d;
  logic [7:0]        seg_out_q, seg_out_d;

  logic [3:0]        step_tens, step_ones;
  logic [5:0]        step_base;
  logic [3:0]        digit_val;
  logic              digit_blank;

  // Four-digit BCD increment with decimal carry between nibbles.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp always off.
  function automatic logic [7:0] seg_code(input logic [3:0] v);
    logic [7:0] c;
    case (v)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = SegOff;
    endcase
    return c;
  endfunction

  // Timer state follows the game FSM status directly every cycle.
  always_comb begin
    state_d = StIdle;
    unique case (game_status)
      2'b01:   state_d = StRun;
      2'b11:   state_d = StHold;
      default: state_d = StIdle;
    endcase
  end

  // Prescaler and BCD seconds count; the count saturates but the prescaler keeps running.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    case (state_q)
      StIdle: begin
        presc_d = '0;
        sec_d   = '0;
      end
      StRun: begin
        if (presc_q == PreMax) begin
          presc_d = '0;
          if (sec_q != SecSat) begin
            sec_d = bcd_inc(sec_q);
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: begin
        presc_d = presc_q;
        sec_d   = sec_q;
      end
    endcase
  end

  // Blink flag toggles every half second of HOLD; forced low otherwise.
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (state_q == StHold) begin
      blink_d = blink_q;
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Binary move count (0..63) to two BCD digits.
  always_comb begin
    step_tens = 4'd0;
    step_base = 6'd0;
    if (step_number >= 6'd60) begin
      step_tens = 4'd6;
      step_base = 6'd60;
    end else if (step_number >= 6'd50) begin
      step_tens = 4'd5;
      step_base = 6'd50;
    end else if (step_number >= 6'd40) begin
      step_tens = 4'd4;
      step_base = 6'd40;
    end else if (step_number >= 6'd30) begin
      step_tens = 4'd3;
      step_base = 6'd30;
    end else if (step_number >= 6'd20) begin
      step_tens = 4'd2;
      step_base = 6'd20;
    end else if (step_number >= 6'd10) begin
      step_tens = 4'd1;
      step_base = 6'd10;
    end
    step_ones = 4'(step_number - step_base);
  end

  // Scan timing: dwell SCAN_DIV cycles on each digit, index wraps 7->0.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (scan_cnt_q == ScanMax) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 3'd1;
    end
  end

  // Select the value and blanking for the digit currently being scanned.
  always_comb begin
    digit_val   = 4'd0;
    digit_blank = 1'b0;
    case (digit_q)
      3'd7:    digit_val = sec_q[15:12];
      3'd6:    digit_val = sec_q[11:8];
      3'd5:    digit_val = sec_q[7:4];
      3'd4:    digit_val = sec_q[3:0];
      3'd1: begin
        digit_val   = step_tens;
        digit_blank = blink_q;
      end
      3'd0: begin
        digit_val   = step_ones;
        digit_blank = blink_q;
      end
      default: digit_blank = 1'b1;
    endcase
  end

  // Next registered anode/segment drive; one-hot-low anode guarantees a single lit digit.
  always_comb begin
    seg_an_d  = SegOff;
    seg_out_d = SegOff;
    if (!digit_blank) begin
      seg_an_d  = ~(8'b1 << digit_q);
      seg_out_d = seg_code(digit_val);
    end
  end

  // State register and all counters.
  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      sec_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      scan_cnt_q  <= '0;
      digit_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_q     <= digit_d;
    end
  end

  // Registered display outputs; dark while in reset.
  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      seg_an_q  <= SegOff;
      seg_out_q <= SegOff;
    end else begin
      seg_an_q  <= seg_an_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign seg_an  = seg_an_q;
  assign seg_out = seg_out_q;

endmodule

// File: tb/tb_game_seg_display.sv
// Directed bench for game_seg_display. A fast instance (SEC_DIV=10, SCAN_DIV=2)
// covers scan order, counting, hold/blink, resume, clearing and async reset; a
// second instance (SEC_DIV=2) runs long enough to reach the 9999 saturation point.
module tb_game_seg_display;

  logic       clk_d = 1'b0;
  logic       rst, rst2;
  logic [1:0] gs, gs2;
  logic [5:0] step, step2;
  logic [7:0] seg_an, seg_out, seg_an2, seg_out2;

  int n_cmp = 0;
  int n_bad = 0;
  int k     = 0;  // rising edges since last reset release of the main instance

  always #5 clk_d = ~clk_d;

  game_seg_display #(.SEC_DIV(10), .SCAN_DIV(2)) u_dut (
    .clk_d      (clk_d),
    .rst        (rst),
    .game_status(gs),
    .step_number(step),
    .seg_an     (seg_an),
    .seg_out    (seg_out)
  );

  game_seg_display #(.SEC_DIV(2), .SCAN_DIV(2)) u_sat (
    .clk_d      (clk_d),
    .rst        (rst2),
    .game_status(gs2),
    .step_number(step2),
    .seg_an     (seg_an2),
    .seg_out    (seg_out2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_d);
    k++;
    @(negedge clk_d);
  endtask

  function automatic logic [7:0] code(input int v);
    case (v)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Blink flag after the e-th edge of HOLD (edge 1 is the one entering HOLD).
  function automatic int blink_after(input int e);
    if (e < 1) return 0;
    return ((e - 1) / 5) % 2;
  endfunction

  // Check n consecutive registered display frames against the expected scan.
  task automatic scan_chk(input string tag, input int n, input logic [15:0] sec,
                          input int tens, input int ones, input bit hold);
    int          d, v;
    bit          blank;
    logic [15:0] sh;
    logic [7:0]  ea, eo;
    for (int e = 1; e <= n; e++) begin
      tick();
      d     = ((k - 1) / 2) % 8;
      blank = (d == 2) || (d == 3) || (d < 2 && hold && blink_after(e - 1) == 1);
      if (d == 0) v = ones;
      else if (d == 1) v = tens;
      else if (d >= 4) begin
        sh = sec >> (4 * (d - 4));
        v  = int'(sh[3:0]);
      end else v = 0;
      ea = blank ? 8'hFF : ~(8'b1 << d);
      eo = blank ? 8'hFF : code(v);
      chk({tag, "_an"}, {24'h0, seg_an}, {24'h0, ea});
      chk({tag, "_out"}, {24'h0, seg_out}, {24'h0, eo});
      if (hold) chk({tag, "_blink"}, {31'h0, u_dut.blink_q}, blink_after(e));
    end
  endtask

  initial begin
    int w;
    rst = 1'b1; rst2 = 1'b1; gs = 2'b00; gs2 = 2'b00; step = 6'd0; step2 = 6'd0;
    #1;
    rst = 1'b0; rst2 = 1'b0;
    repeat (3) @(negedge clk_d);
    chk("rst_an", {24'h0, seg_an}, 32'hFF);
    chk("rst_out", {24'h0, seg_out}, 32'hFF);
    chk("rst_sec", {16'h0, u_dut.sec_q}, 32'h0);

    // Release between edges; scan starts at digit 0 one edge later.
    rst = 1'b1; rst2 = 1'b1; gs2 = 2'b01; k = 0;
    scan_chk("idle_scan", 16, 16'h0000, 0, 0, 1'b0);

    // 125 cycles of RUN: 124 prescaler steps -> 12 s, prescaler at 4.
    gs = 2'b01;
    repeat (125) tick();
    chk("run125_sec", {16'h0, u_dut.sec_q}, 32'h0012);
    chk("run125_pre", 32'(u_dut.presc_q), 32'd4);

    // Win: count freezes at 12, step digits blink with a 5-cycle half period.
    gs = 2'b11;
    scan_chk("hold12", 16, 16'h0012, 0, 0, 1'b1);
    chk("hold12_sec", {16'h0, u_dut.sec_q}, 32'h0012);
    chk("hold12_pre", 32'(u_dut.presc_q), 32'd5);

    // GAME_INITIAL clears everything on the edge after entering IDLE.
    gs = 2'b10;
    repeat (2) tick();
    chk("idle_sec", {16'h0, u_dut.sec_q}, 32'h0);
    chk("idle_pre", 32'(u_dut.presc_q), 32'd0);
    chk("idle_blink", {31'h0, u_dut.blink_q}, 32'd0);

    // 35 RUN cycles -> 3 s, then HOLD.
    gs = 2'b01;
    repeat (35) tick();
    chk("run35_sec", {16'h0, u_dut.sec_q}, 32'h0003);
    gs = 2'b11;
    scan_chk("hold3", 20, 16'h0003, 0, 0, 1'b1);
    chk("hold3_pre", 32'(u_dut.presc_q), 32'd5);

    // Resume from 5: one edge to re-enter RUN, then 5 steps wrap to 0 and reach 4 s.
    gs = 2'b01;
    repeat (6) tick();
    chk("resume_sec", {16'h0, u_dut.sec_q}, 32'h0004);
    chk("resume_pre", 32'(u_dut.presc_q), 32'd0);

    // Move count 63 -> tens 6 (82), ones 3 (B0).
    gs = 2'b00;
    repeat (2) tick();
    step = 6'd63;
    scan_chk("step63", 16, 16'h0000, 6, 3, 1'b0);

    // Asynchronous reset mid-RUN, asserted between edges.
    gs = 2'b01;
    repeat (17) tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_an", {24'h0, seg_an}, 32'hFF);
    chk("arst_out", {24'h0, seg_out}, 32'hFF);
    chk("arst_sec", {16'h0, u_dut.sec_q}, 32'h0);
    chk("arst_pre", 32'(u_dut.presc_q), 32'd0);
    @(negedge clk_d);
    rst = 1'b1; k = 0;
    scan_chk("arst_scan", 4, 16'h0000, 6, 3, 1'b0);

    // Saturation: wait for 9999 on the fast-second instance.
    w = 0;
    while (u_sat.sec_q != 16'h9999 && w < 25000) begin
      tick();
      w++;
    end
    chk("sat_reach", {16'h0, u_sat.sec_q}, 32'h9999);
    chk("sat_pre0", 32'(u_sat.presc_q), 32'd0);
    repeat (31) tick();
    chk("sat_hold", {16'h0, u_sat.sec_q}, 32'h9999);
    chk("sat_pre1", 32'(u_sat.presc_q), 32'd1);
    w = 0;
    while (seg_an2 != 8'h7F && w < 20) begin
      tick();
      w++;
    end
    chk("sat_d7_an", {24'h0, seg_an2}, 32'h7F);
    chk("sat_d7_out", {24'h0, seg_out2}, 32'h90);
    w = 0;
    while (seg_an2 != 8'hEF && w < 20) begin
      tick();
      w++;
    end
    chk("sat_d4_an", {24'h0, seg_an2}, 32'hEF);
    chk("sat_d4_out", {24'h0, seg_out2}, 32'h90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
